// File: rtl/time_entry_loader_pkg.sv
// Shared definitions for the microwave MM:SS time-entry loader:
// FSM state encodings, BCD widths and packed-digit field offsets.
package time_entry_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_LOAD  = 3'd2,
        ST_RUN   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam int BCD_W            = 4;
    localparam int BCD_MAX          = 9;
    localparam int SEC_TENS_MAX_DEF = 5;
    localparam int NUM_DIGITS       = 4;
    localparam int DIGITS_W         = NUM_DIGITS * BCD_W;
    localparam int COUNT_W          = 3;

    // Digit slots inside the packed {min_tens,min_ones,sec_tens,sec_ones} word
    localparam int SEC_ONES_IDX = 0;
    localparam int SEC_TENS_IDX = 1;
    localparam int MIN_ONES_IDX = 2;
    localparam int MIN_TENS_IDX = 3;

    function automatic logic [BCD_W-1:0] get_digit(input logic [DIGITS_W-1:0] d,
                                                   input int idx);
        return d[idx*BCD_W +: BCD_W];
    endfunction

endpackage

// File: rtl/time_entry_loader_if.sv
// Keypad-side and timer-chain-side signals of the time-entry loader.
// The loader itself uses the slave view; the driver of keys/timer_zero uses master.
interface time_entry_loader_if;
    import time_entry_loader_pkg::*;

    logic                 key_valid;
    logic [BCD_W-1:0]     key_code;
    logic                 start;
    logic                 cancel;
    logic                 timer_zero;
    logic [DIGITS_W-1:0]  timer_digits;
    logic                 timer_load;
    logic                 timer_clear;
    logic                 timer_stop;
    logic [COUNT_W-1:0]   entry_count;
    logic                 err_o;
    logic                 done_o;

    modport master (
        output key_valid, key_code, start, cancel, timer_zero,
        input  timer_digits, timer_load, timer_clear, timer_stop,
               entry_count, err_o, done_o
    );

    modport slave (
        input  key_valid, key_code, start, cancel, timer_zero,
        output timer_digits, timer_load, timer_clear, timer_stop,
               entry_count, err_o, done_o
    );

endinterface

// File: rtl/time_entry_loader_bcd_entry_shift.sv
// Four-digit BCD entry buffer: new digits enter at sec_ones and push the
// others left; the digit count saturates and then further keys are ignored.
module bcd_entry_shift
    import time_entry_loader_pkg::*;
#(
    parameter int MAX_DIGITS = 4
) (
    input  logic                clk,
    input  logic                clear,
    input  logic                clr,
    input  logic                shift_req,
    input  logic [BCD_W-1:0]    key_code,
    output logic                key_ok,
    output logic [DIGITS_W-1:0] digits,
    output logic [COUNT_W-1:0]  count
);

    logic [DIGITS_W-1:0] digits_reg;
    logic [DIGITS_W-1:0] digits_next;
    logic [COUNT_W-1:0]  count_reg;
    logic                accept;

    assign key_ok = (key_code <= BCD_W'(BCD_MAX));
    assign accept = shift_req && key_ok && (count_reg < COUNT_W'(MAX_DIGITS));

    // Whole-digit shift: each slot takes its lower neighbour, no binary carry
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_shift
            if (gi == 0) begin : g_lsb
                assign digits_next[gi*BCD_W +: BCD_W] = key_code;
            end else begin : g_upper
                assign digits_next[gi*BCD_W +: BCD_W] = digits_reg[(gi-1)*BCD_W +: BCD_W];
            end
        end
    endgenerate

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            digits_reg <= '0;
            count_reg  <= '0;
        end else if (clr) begin
            digits_reg <= '0;
            count_reg  <= '0;
        end else if (accept) begin
            digits_reg <= digits_next;
            count_reg  <= count_reg + COUNT_W'(1);
        end
    end

    assign digits = digits_reg;
    assign count  = count_reg;

endmodule

// File: rtl/time_entry_loader.sv
// Keypad-side writer for the MM:SS down-counter chain: collects digits,
// validates them on start, pulses a parallel load, runs and detects expiry.
module time_entry_loader
    import time_entry_loader_pkg::*;
#(
    parameter int MAX_DIGITS   = 4,
    parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF,
    parameter int DONE_CYCLES  = 3
) (
    input  logic                 clk,
    input  logic                 clear,
    time_entry_loader_if.slave   bus
);

    localparam int DCW = (DONE_CYCLES > 1) ? $clog2(DONE_CYCLES) : 1;
    localparam logic [DCW-1:0]   DONE_LAST    = DCW'(DONE_CYCLES - 1);
    localparam logic [BCD_W-1:0] SEC_TENS_LIM = BCD_W'(SEC_TENS_MAX);

    state_t              state_reg, state_next;
    logic                run_first_reg;
    logic [DCW-1:0]      done_cnt_reg;
    logic                err_reg, err_next;
    logic                tclr_reg, tclr_next;
    logic                buf_clr;
    logic                key_req;
    logic                key_ok;
    logic                start_bad;
    logic [DIGITS_W-1:0] digits;
    logic [COUNT_W-1:0]  count;

    bcd_entry_shift #(
        .MAX_DIGITS (MAX_DIGITS)
    ) u_shift (
        .clk       (clk),
        .clear     (clear),
        .clr       (buf_clr),
        .shift_req (key_req),
        .key_code  (bus.key_code),
        .key_ok    (key_ok),
        .digits    (digits),
        .count     (count)
    );

    assign start_bad = (get_digit(digits, SEC_TENS_IDX) > SEC_TENS_LIM) || (digits == '0);

    always_comb begin
        state_next = state_reg;
        buf_clr    = 1'b0;
        key_req    = 1'b0;
        err_next   = 1'b0;
        tclr_next  = 1'b0;
        if (bus.cancel) begin
            state_next = ST_IDLE;
            buf_clr    = 1'b1;
            tclr_next  = (state_reg == ST_LOAD) || (state_reg == ST_RUN) ||
                         (state_reg == ST_DONE);
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    // start here has an empty buffer: ignored, and any key with it is dropped
                    if (!bus.start && bus.key_valid && key_ok) begin
                        key_req    = 1'b1;
                        state_next = ST_ENTRY;
                    end
                end
                ST_ENTRY: begin
                    if (bus.start) begin
                        if (start_bad) begin
                            err_next   = 1'b1;
                            buf_clr    = 1'b1;
                            state_next = ST_IDLE;
                        end else begin
                            state_next = ST_LOAD;
                        end
                    end else if (bus.key_valid) begin
                        key_req = 1'b1;
                    end
                end
                ST_LOAD: state_next = ST_RUN;
                ST_RUN: begin
                    // Chain value only lands at the LOAD edge, so skip the first RUN cycle
                    if (!run_first_reg && bus.timer_zero) begin
                        state_next = ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (done_cnt_reg == DONE_LAST) begin
                        state_next = ST_IDLE;
                        buf_clr    = 1'b1;
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state_reg     <= ST_IDLE;
            run_first_reg <= 1'b0;
            done_cnt_reg  <= '0;
            err_reg       <= 1'b0;
            tclr_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            run_first_reg <= (state_reg == ST_LOAD);
            done_cnt_reg  <= (state_reg == ST_DONE) ? done_cnt_reg + DCW'(1) : '0;
            err_reg       <= err_next;
            tclr_reg      <= tclr_next;
        end
    end

    assign bus.timer_digits = digits;
    assign bus.entry_count  = count;
    assign bus.timer_load   = (state_reg == ST_LOAD);
    assign bus.timer_stop   = (state_reg != ST_RUN);
    assign bus.timer_clear  = tclr_reg;
    assign bus.err_o        = err_reg;
    assign bus.done_o       = (state_reg == ST_DONE);

endmodule

// File: tb/tb_time_entry_loader.sv
// Directed bench for time_entry_loader: digit entry, validation, load/run/done
// sequencing, cancel and asynchronous clear.
module tb_time_entry_loader;

    logic clk = 1'b0;
    logic clear;
    int   n_checks = 0;
    int   n_errors = 0;

    time_entry_loader_if bus ();

    time_entry_loader #(
        .MAX_DIGITS   (4),
        .SEC_TENS_MAX (5),
        .DONE_CYCLES  (3)
    ) dut (
        .clk   (clk),
        .clear (clear),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic key(input logic [3:0] k);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        step();
        bus.key_valid = 1'b0;
    endtask

    task automatic press_start();
        bus.start = 1'b1;
        step();
        bus.start = 1'b0;
    endtask

    initial begin
        bus.key_valid  = 1'b0;
        bus.key_code   = 4'd0;
        bus.start      = 1'b0;
        bus.cancel     = 1'b0;
        bus.timer_zero = 1'b0;
        clear          = 1'b1;
        step();
        step();
        check("rst_digits", 32'(bus.timer_digits), 32'h0);
        check("rst_count",  32'(bus.entry_count), 32'd0);
        check("rst_load",   32'(bus.timer_load), 32'd0);
        check("rst_tclr",   32'(bus.timer_clear), 32'd0);
        check("rst_err",    32'(bus.err_o), 32'd0);
        check("rst_done",   32'(bus.done_o), 32'd0);
        check("rst_stop",   32'(bus.timer_stop), 32'd1);
        clear = 1'b0;
        step();

        // Saturating entry: 1,2,3,4 accepted, 5 ignored; code 12 never counts
        key(4'd12);
        check("bad_code_count", 32'(bus.entry_count), 32'd0);
        key(4'd1);
        check("k1_count", 32'(bus.entry_count), 32'd1);
        key(4'd2); key(4'd3); key(4'd4);
        check("k4_digits", 32'(bus.timer_digits), 32'h1234);
        key(4'd5);
        check("sat_count",  32'(bus.entry_count), 32'd4);
        check("sat_digits", 32'(bus.timer_digits), 32'h1234);
        bus.cancel = 1'b1; step(); bus.cancel = 1'b0;
        check("cancel_entry_count", 32'(bus.entry_count), 32'd0);
        check("cancel_entry_tclr",  32'(bus.timer_clear), 32'd0);

        // start in IDLE with empty buffer: no error
        press_start();
        check("idle_start_err", 32'(bus.err_o), 32'd0);

        // 0070: sec_tens 7 rejected
        key(4'd7); key(4'd0);
        check("k70_digits", 32'(bus.timer_digits), 32'h0070);
        press_start();
        check("k70_err",   32'(bus.err_o), 32'd1);
        check("k70_load",  32'(bus.timer_load), 32'd0);
        check("k70_count", 32'(bus.entry_count), 32'd0);
        step();
        check("k70_err_gone", 32'(bus.err_o), 32'd0);
        check("k70_noload",   32'(bus.timer_load), 32'd0);

        // All zeros rejected
        key(4'd0); key(4'd0);
        press_start();
        check("zero_err", 32'(bus.err_o), 32'd1);
        step();

        // 1,3,0 -> load 0130, then run; timer_zero in first RUN cycle ignored
        key(4'd1); key(4'd3); key(4'd0);
        press_start();
        check("k130_load",   32'(bus.timer_load), 32'd1);
        check("k130_digits", 32'(bus.timer_digits), 32'h0130);
        check("k130_stop_ld", 32'(bus.timer_stop), 32'd1);
        check("k130_tclr_ld", 32'(bus.timer_clear), 32'd0);
        bus.key_valid = 1'b1; bus.key_code = 4'd8;
        step();
        bus.key_valid = 1'b0;
        check("run1_load",   32'(bus.timer_load), 32'd0);
        check("run1_stop",   32'(bus.timer_stop), 32'd0);
        check("run_key_ign", 32'(bus.timer_digits), 32'h0130);
        bus.timer_zero = 1'b1;
        step();
        check("run1_zero_ign", 32'(bus.timer_stop), 32'd0);
        check("run1_no_done",  32'(bus.done_o), 32'd0);
        step();
        bus.timer_zero = 1'b0;
        check("done1_stop", 32'(bus.timer_stop), 32'd1);
        check("done1",      32'(bus.done_o), 32'd1);
        step();
        check("done2", 32'(bus.done_o), 32'd1);
        step();
        check("done3", 32'(bus.done_o), 32'd1);
        step();
        check("done_exit",        32'(bus.done_o), 32'd0);
        check("done_exit_count",  32'(bus.entry_count), 32'd0);
        check("done_exit_digits", 32'(bus.timer_digits), 32'h0);

        // 5,9 -> sec_tens 5 is legal; cancel during LOAD pulses timer_clear
        key(4'd5); key(4'd9);
        press_start();
        check("k59_load", 32'(bus.timer_load), 32'd1);
        bus.cancel = 1'b1; step(); bus.cancel = 1'b0;
        check("cancel_ld_tclr", 32'(bus.timer_clear), 32'd1);
        check("cancel_ld_load", 32'(bus.timer_load), 32'd0);

        // 2,0,0 -> run, then cancel mid-RUN together with start and key 9
        key(4'd2); key(4'd0); key(4'd0);
        press_start();
        step(); step();
        check("k200_run_stop", 32'(bus.timer_stop), 32'd0);
        bus.cancel = 1'b1; bus.start = 1'b1; bus.key_valid = 1'b1; bus.key_code = 4'd9;
        step();
        bus.cancel = 1'b0; bus.start = 1'b0; bus.key_valid = 1'b0;
        check("cancel_run_tclr",  32'(bus.timer_clear), 32'd1);
        check("cancel_run_stop",  32'(bus.timer_stop), 32'd1);
        check("cancel_run_count", 32'(bus.entry_count), 32'd0);
        check("cancel_run_load",  32'(bus.timer_load), 32'd0);
        step();
        check("cancel_tclr_1cyc", 32'(bus.timer_clear), 32'd0);

        // start + key 9 together in IDLE: key dropped
        bus.start = 1'b1; bus.key_valid = 1'b1; bus.key_code = 4'd9;
        step();
        bus.start = 1'b0; bus.key_valid = 1'b0;
        check("start_key_drop", 32'(bus.entry_count), 32'd0);

        // Asynchronous clear while running
        key(4'd5);
        press_start();
        step();
        check("clr_pre_stop", 32'(bus.timer_stop), 32'd0);
        clear = 1'b1;
        #1;
        check("clr_stop",  32'(bus.timer_stop), 32'd1);
        check("clr_load",  32'(bus.timer_load), 32'd0);
        check("clr_tclr",  32'(bus.timer_clear), 32'd0);
        check("clr_done",  32'(bus.done_o), 32'd0);
        check("clr_count", 32'(bus.entry_count), 32'd0);
        #1;
        clear = 1'b0;
        step();
        key(4'd4);
        check("post_clr_idle_key", 32'(bus.entry_count), 32'd1);
        check("post_clr_digits",   32'(bus.timer_digits), 32'h0004);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
